// File: rtl/up5bit_count_checker.sv
// Checks a fabric up-counter against an expected sequence of NUM_SAMPLES valid samples.
// Define UP5BIT_CHECKER_STOP_ON_FAIL_EN to end a run on the first failing compare.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | comparing valid samples against the expected count
// DONE  | run finished, error_count/pass held until the next start
module up5bit_count_checker #(
    parameter int WIDTH       = 5,
    parameter int NUM_SAMPLES = 32,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             busy,
    output logic             mismatch,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] error_count
);
    localparam int               IDX_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             busy_q, done_q, pass_q, mismatch_q;
    logic             cmp_fail, last_sample, stop_run;

    assign cmp_fail    = sample_valid && (sample != expected_q);
    assign last_sample = (index_q == LAST_IDX);
    assign expected_d  = expected_q + WIDTH'(1);
    assign index_d     = index_q + IDX_W'(1);
    assign err_d       = (cmp_fail && (err_q != ERR_MAX)) ? err_q + ERR_W'(1) : err_q;

`ifdef UP5BIT_CHECKER_STOP_ON_FAIL_EN
    assign stop_run = last_sample || cmp_fail;
`else
    assign stop_run = last_sample;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            expected_q <= '0;
            index_q    <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        expected_q <= seed;
                        index_q    <= '0;
                        err_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here
                    if (sample_valid) begin
                        expected_q <= expected_d;
                        index_q    <= index_d;
                        err_q      <= err_d;
                        mismatch_q <= cmp_fail;
                        if (stop_run) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign mismatch    = mismatch_q;
    assign error_count = err_q;

endmodule

// File: doc/up5bit_count_checker.md
UP5BIT_COUNT_CHECKER -- requirements
Module: up5bit_count_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 5, the checked count width in bits.
REQ-002 SHALL have parameter NUM_SAMPLES, default 32, the valid samples per check run (range 1..256).
REQ-003 SHALL have parameter ERR_W, default 8, the error counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  run request, sampled in IDLE or DONE.
REQ-007 SHALL have port seed  input  WIDTH  expected value of the first sample, captured on accepted start.
REQ-008 SHALL have port sample_valid  input  1  qualifies sample this cycle.
REQ-009 SHALL have port sample  input  WIDTH  fabric counter output under check.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port mismatch  output  1  one-cycle pulse, registered, the cycle after a failing compare.
REQ-012 SHALL have port done  output  1  high while in DONE.
REQ-013 SHALL have port pass  output  1  high in DONE when error_count equals 0.
REQ-014 SHALL have port error_count  output  ERR_W  failing compares in the current or last run.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; all outputs driven from registers.
REQ-016 SHALL, in IDLE or DONE with start=1, load expected=seed, sample index=0, error_count=0, and enter RUN next cycle.
REQ-017 SHALL ignore start while in RUN.
REQ-018 SHALL, in RUN on each cycle with sample_valid=1, compare sample against expected and advance expected by 1 modulo 2**WIDTH (31 -> 0 wraps, no error).
REQ-019 SHALL ignore cycles with sample_valid=0 in RUN; expected and index hold.
REQ-020 SHALL increment error_count on each failing compare, saturating at 2**ERR_W-1.
REQ-021 SHALL assert mismatch for exactly one cycle, one cycle after each failing compare; back-to-back failures give back-to-back pulses.
REQ-022 SHALL enter DONE on the cycle after the NUM_SAMPLES-th valid sample is compared; that sample's result is counted.
REQ-023 SHALL hold error_count and pass stable in DONE until the next accepted start.
REQ-024 SHALL, in RUN with start=1 and sample_valid=1 in the same cycle, process the sample and ignore start.
REQ-025 SHALL deassert pass in every state other than DONE.

Reset
REQ-026 SHALL, on reset=1, asynchronously force state=IDLE, busy=0, done=0, pass=0, mismatch=0, error_count=0, expected=0, index=0.
REQ-027 SHALL, when reset asserts mid-RUN, discard the run; after release the block sits in IDLE awaiting start.
REQ-028 SHALL ignore start while reset is high; the first start is accepted on the first rising edge after reset falls.

Configuration
REQ-029 SHALL, with macro UP5BIT_CHECKER_STOP_ON_FAIL_EN defined, enter DONE on the cycle after the first failing compare, with error_count=1 and pass=0.
REQ-030 SHALL, with the macro undefined, always consume all NUM_SAMPLES valid samples regardless of failures.

Verification
REQ-031 SHALL cover: seed=0, 32 valid samples 0..31 in consecutive cycles -> done=1 after the 32nd sample, pass=1, error_count=0, mismatch never set.
REQ-032 SHALL cover: seed=1, samples 1..31,0 with sample_valid deasserted every other cycle -> wrap 31->0 accepted, pass=1, done reached 64 cycles after start.
REQ-033 SHALL cover: seed=0, sample 5 replaced by 7 and sample 6 by 0 -> two consecutive mismatch pulses, error_count=2, pass=0 (macro undefined); with macro defined -> done the cycle after the sample-5 compare, error_count=1.
REQ-034 SHALL cover: reset asserted after 10 samples of a run -> all outputs 0 immediately, no done; a new start with seed=3 and samples 3..2 -> pass=1.
REQ-035 SHALL cover: start pulsed during RUN at sample 12 with seed=9 -> ignored, run completes against the original seed, pass=1.
REQ-036 SHALL cover: ERR_W=2, NUM_SAMPLES=32, all 32 samples wrong -> error_count saturates at 3, pass=0.
